scr1_trace_encoder: RTL

Synthesizable retire-trace encoder sitting downstream of the pipeline's MPRF write port and EXU PC-update strobe (the same event sources the simulation tracelog consumes). Each cycle that retires a PC update and/or a register write is packed into a record and buffered in a small FIFO. A serializer FSM streams the records as a byte stream over a valid/ready port to an off-core trace sink. FIFO overflow drops whole records and reports the loss count in-band.

---
 rtl/scr1_trace_encoder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/scr1_trace_encoder.sv
// Retire-trace encoder: packs PC/MPRF (and optionally CSR) updates into records, buffers them, streams bytes.
// Optional CSR capture is compiled in with `define SCR1_TRACE_CSR_EN.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_ADDR_WIDTH
`define SCR1_MPRF_ADDR_WIDTH 5
`endif

module scr1_trace_encoder #(
  parameter int SCR1_TRACE_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             trace_en,
  input  logic                             update_pc_en,
  input  logic [`SCR1_XLEN-1:0]            update_pc,
  input  logic                             mprf_wr_en,
  input  logic [`SCR1_MPRF_ADDR_WIDTH-1:0] mprf_wr_addr,
  input  logic [`SCR1_XLEN-1:0]            mprf_wr_data,
`ifdef SCR1_TRACE_CSR_EN
  input  logic                             csr_wr_en,
  input  logic [11:0]                      csr_wr_addr,
  input  logic [`SCR1_XLEN-1:0]            csr_wr_data,
`endif
  output logic                             trc_valid,
  input  logic                             trc_ready,
  output logic [7:0]                       trc_data,
  output logic                             trc_idle
);

  localparam int DEPTH = SCR1_TRACE_FIFO_DEPTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int XLEN  = `SCR1_XLEN;
  localparam int AW    = `SCR1_MPRF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DROP,
    ST_PC,
    ST_RADDR,
    ST_RDATA
`ifdef SCR1_TRACE_CSR_EN
    , ST_CADDR,
    ST_CDATA
`endif
  } state_t;

  state_t           state, state_nxt, field_nxt;
  state_t           after_hdr, after_drop, after_pc, after_rdata;
  logic [1:0]       idx, idx_nxt;
  logic             field_last;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       drop_cnt;
  logic             ev_pc, ev_reg, push_req, push_ok, pop, full, drop;
  logic             head_pc, head_reg, head_csr, head_ovf;

  logic             mem_pc_v  [DEPTH];
  logic             mem_reg_v [DEPTH];
  logic             mem_ovf   [DEPTH];
  logic [7:0]       mem_drop  [DEPTH];
  logic [XLEN-1:0]  mem_pc    [DEPTH];
  logic [AW-1:0]    mem_raddr [DEPTH];
  logic [XLEN-1:0]  mem_rdata [DEPTH];

  assign ev_pc  = update_pc_en;
  assign ev_reg = mprf_wr_en & (mprf_wr_addr != '0);

`ifdef SCR1_TRACE_CSR_EN
  logic             ev_csr;
  logic             mem_csr_v [DEPTH];
  logic [11:0]      mem_caddr [DEPTH];
  logic [XLEN-1:0]  mem_cdata [DEPTH];

  assign ev_csr   = csr_wr_en;
  assign push_req = trace_en & (ev_pc | ev_reg | ev_csr);
  assign head_csr = mem_csr_v[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_csr_v[wr_ptr] <= ev_csr;
      mem_caddr[wr_ptr] <= csr_wr_addr;
      mem_cdata[wr_ptr] <= csr_wr_data;
    end
  end
`else
  assign push_req = trace_en & (ev_pc | ev_reg);
  assign head_csr = 1'b0;
`endif

  // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  assign head_pc  = mem_pc_v[rd_ptr];
  assign head_reg = mem_reg_v[rd_ptr];
  assign head_ovf = mem_ovf[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc_v[wr_ptr]  <= ev_pc;
      mem_reg_v[wr_ptr] <= ev_reg;
      mem_ovf[wr_ptr]   <= (drop_cnt != 8'd0);
      mem_drop[wr_ptr]  <= drop_cnt;
      mem_pc[wr_ptr]    <= update_pc;
      mem_raddr[wr_ptr] <= mprf_wr_addr;
      mem_rdata[wr_ptr] <= mprf_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_ok)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Field successor chain for the head record; ST_IDLE here means "record done".
  always_comb begin
    after_rdata = ST_IDLE;
`ifdef SCR1_TRACE_CSR_EN
    if (head_csr) after_rdata = ST_CADDR;
`endif
    after_pc   = head_reg ? ST_RADDR : after_rdata;
    after_drop = head_pc  ? ST_PC    : after_pc;
    after_hdr  = head_ovf ? ST_DROP  : after_drop;
  end

  always_comb begin
    field_nxt  = ST_IDLE;
    field_last = 1'b0;
    case (state)
      ST_HDR:   begin field_nxt = after_hdr;   field_last = 1'b1;         end
      ST_DROP:  begin field_nxt = after_drop;  field_last = 1'b1;         end
      ST_PC:    begin field_nxt = after_pc;    field_last = (idx == 2'd3); end
      ST_RADDR: begin field_nxt = ST_RDATA;    field_last = 1'b1;         end
      ST_RDATA: begin field_nxt = after_rdata; field_last = (idx == 2'd3); end
`ifdef SCR1_TRACE_CSR_EN
      ST_CADDR: begin field_nxt = ST_CDATA;    field_last = (idx == 2'd1); end
      ST_CDATA: begin field_nxt = ST_IDLE;     field_last = (idx == 2'd3); end
`endif
      default:  begin field_nxt = ST_IDLE;     field_last = 1'b0;         end
    endcase
  end

  assign pop = (state != ST_IDLE) & trc_ready & field_last & (field_nxt == ST_IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == ST_IDLE) begin
      if (count != '0 || push_ok) state_nxt = ST_HDR;
    end else if (trc_ready) begin
      if (field_last) begin
        idx_nxt = '0;
        if (field_nxt == ST_IDLE)
          state_nxt = (count > CNT_W'(1) || push_ok) ? ST_HDR : ST_IDLE;
        else
          state_nxt = field_nxt;
      end else begin
        idx_nxt = idx + 2'd1;
      end
    end
  end

  always_comb begin
    trc_data = 8'h00;
    case (state)
      ST_HDR:   trc_data = {head_ovf, 4'b0000, head_csr, head_reg, head_pc};
      ST_DROP:  trc_data = mem_drop[rd_ptr];
      ST_PC:    trc_data = mem_pc[rd_ptr][{idx, 3'b000} +: 8];
      ST_RADDR: trc_data = {{(8-AW){1'b0}}, mem_raddr[rd_ptr]};
      ST_RDATA: trc_data = mem_rdata[rd_ptr][{idx, 3'b000} +: 8];
`ifdef SCR1_TRACE_CSR_EN
      ST_CADDR: trc_data = idx[0] ? {4'b0000, mem_caddr[rd_ptr][11:8]} : mem_caddr[rd_ptr][7:0];
      ST_CDATA: trc_data = mem_cdata[rd_ptr][{idx, 3'b000} +: 8];
`endif
      default:  trc_data = 8'h00;
    endcase
  end

  assign trc_valid = (state != ST_IDLE);
  assign trc_idle  = (count == '0) & (state == ST_IDLE);

endmodule
